// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage.
// Holds the fetch FSM encoding, instruction width and default bubble word.
package fetch_stage_pkg;

    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h00000000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold enable and flush-to-bubble.
// Flush wins over enable and keeps the previous pc/pc4.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic [31:0]       i_pc,
    input  logic [INST_W-1:0] i_inst,
    output logic              o_valid,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_pc4,
    output logic [INST_W-1:0] o_inst
);

    logic              r_valid;
    logic [31:0]       r_pc;
    logic [31:0]       r_pc4;
    logic [INST_W-1:0] r_inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0;
            r_pc4   <= 32'h0;
            r_inst  <= NOP_INST;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end else if (i_en) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_pc4   <= i_pc + 32'd4;
            r_inst  <= i_inst;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_inst  = r_inst;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/FAULT control, IF/ID register.
// A misaligned redirect parks the stage in FAULT until reset.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0]       RESET_PC = 32'h00000000,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    output logic [31:0]       imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    output logic              if_id_valid,
    output logic [31:0]       if_id_pc,
    output logic [31:0]       if_id_pc4,
    output logic [INST_W-1:0] if_id_inst,
    output logic              fetch_fault
);

    fetch_state_e r_state;
    fetch_state_e w_next_state;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic         w_en;
    logic         w_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
        end
    end

    // Redirect outranks stall; a misaligned target leaves the PC untouched.
    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_en         = 1'b0;
        w_flush      = 1'b0;
        unique case (r_state)
            BOOT: begin
                w_next_state = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    w_flush = 1'b1;
                    if (|redirect_target[1:0]) begin
                        w_next_state = FAULT;
                    end else begin
                        w_pc_next = redirect_target;
                    end
                end else if (!stall) begin
                    w_en      = 1'b1;
                    w_pc_next = r_pc + 32'd4;
                end
            end
            FAULT: begin
                w_next_state = FAULT;
            end
            default: begin
                w_next_state = BOOT;
            end
        endcase
    end

    assign imem_addr   = r_pc;
    assign fetch_fault = (r_state == FAULT);

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_en),
        .i_flush (w_flush),
        .i_pc    (r_pc),
        .i_inst  (imem_inst),
        .o_valid (if_id_valid),
        .o_pc    (if_id_pc),
        .o_pc4   (if_id_pc4),
        .o_inst  (if_id_inst)
    );

endmodule
